// File: rtl/decoder_e_sweep.sv
// rtl/decoder_e_sweep.sv - registered enabled N-to-2^N decoder with self-timed ascending sweep
module decoder_e_sweep #(
    parameter  int INPUT_LENGTH = 5,
    localparam int OUTPUT_WIDTH = 2 ** INPUT_LENGTH
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [INPUT_LENGTH-1:0] in_i,
    input  logic                    enable_i,
    input  logic                    sweep_start_i,
    output logic [OUTPUT_WIDTH-1:0] out_o,
    output logic [INPUT_LENGTH-1:0] out_idx_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int CW = INPUT_LENGTH + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [OUTPUT_WIDTH-1:0] out_q, out_d;
    logic [INPUT_LENGTH-1:0] idx_q, idx_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = '0;
        idx_d   = '0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                // A sweep request wins over a simultaneous normal decode.
                if (sweep_start_i) begin
                    state_d = S_SWEEP;
                    out_d   = OUTPUT_WIDTH'(1);
                    cnt_d   = CW'(1);
                    busy_d  = 1'b1;
                end else if (enable_i) begin
                    out_d = OUTPUT_WIDTH'(1) << in_i;
                    idx_d = in_i;
                end
            end
            S_SWEEP: begin
                busy_d = 1'b1;
                // Counter is one bit wider so the terminal value is distinct from 0.
                if (cnt_q == CW'(OUTPUT_WIDTH)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    out_d = OUTPUT_WIDTH'(1) << cnt_q[INPUT_LENGTH-1:0];
                    idx_d = cnt_q[INPUT_LENGTH-1:0];
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    assign out_o     = out_q;
    assign out_idx_o = idx_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_decoder_e_sweep.sv
// tb/tb_decoder_e_sweep.sv - scoreboard bench for decoder_e_sweep at widths 3 and 1
module tb_decoder_e_sweep;

    typedef struct {
        int         cyc;
        logic [7:0] out;
        logic [2:0] idx;
        logic       busy;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    int         cyc = 0;
    int         tests = 0;
    int         failed = 0;
    exp_t       q3[$];
    exp_t       q1[$];

    logic       rst3, en3, sw3;
    logic [2:0] in3;
    logic [7:0] out3;
    logic [2:0] idx3;
    logic       busy3, done3;

    logic       rst1, en1, sw1;
    logic [0:0] in1;
    logic [1:0] out1;
    logic [0:0] idx1;
    logic       busy1, done1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    decoder_e_sweep #(.INPUT_LENGTH(3)) u3 (
        .clk_i(clk), .rst_n_i(rst3), .in_i(in3), .enable_i(en3), .sweep_start_i(sw3),
        .out_o(out3), .out_idx_o(idx3), .busy_o(busy3), .done_o(done3)
    );

    decoder_e_sweep #(.INPUT_LENGTH(1)) u1 (
        .clk_i(clk), .rst_n_i(rst1), .in_i(in1), .enable_i(en1), .sweep_start_i(sw1),
        .out_o(out1), .out_idx_o(idx1), .busy_o(busy1), .done_o(done1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step3(input logic sw, input logic en, input logic [2:0] in,
                         input logic [7:0] e_out, input logic [2:0] e_idx,
                         input logic e_busy, input logic e_done);
        exp_t e;
        sw3 = sw; en3 = en; in3 = in;
        e.cyc = cyc + 1; e.out = e_out; e.idx = e_idx; e.busy = e_busy; e.done = e_done;
        q3.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic step1(input logic sw, input logic en, input logic in,
                         input logic [1:0] e_out, input logic e_idx,
                         input logic e_busy, input logic e_done);
        exp_t e;
        sw1 = sw; en1 = en; in1 = in;
        e.cyc = cyc + 1; e.out = {6'b0, e_out}; e.idx = {2'b0, e_idx}; e.busy = e_busy; e.done = e_done;
        q1.push_back(e);
        @(posedge clk); #1;
    endtask

    // Monitor: compares whenever an expectation is due this cycle, plus invariants.
    always @(negedge clk) begin
        exp_t e;
        if (q3.size() > 0 && q3[0].cyc <= cyc) begin
            e = q3.pop_front();
            chk("w3 due cycle", 32'(cyc), 32'(e.cyc));
            chk("w3 out_o", 32'(out3), 32'(e.out));
            chk("w3 out_idx_o", 32'(idx3), 32'(e.idx));
            chk("w3 busy_o", 32'(busy3), 32'(e.busy));
            chk("w3 done_o", 32'(done3), 32'(e.done));
        end
        if (q1.size() > 0 && q1[0].cyc <= cyc) begin
            e = q1.pop_front();
            chk("w1 due cycle", 32'(cyc), 32'(e.cyc));
            chk("w1 out_o", 32'(out1), 32'(e.out));
            chk("w1 out_idx_o", 32'(idx1), 32'(e.idx));
            chk("w1 busy_o", 32'(busy1), 32'(e.busy));
            chk("w1 done_o", 32'(done1), 32'(e.done));
        end
        if (rst3 === 1'b1) begin
            chk("w3 onehot", 32'($onehot0(out3)), 32'd1);
            if (out3 != 8'h00) chk("w3 out matches idx", 32'(out3), 32'(8'h01 << idx3));
            if (done3) chk("w3 done implies busy", 32'(busy3), 32'd1);
        end
        if (rst1 === 1'b1) begin
            chk("w1 onehot", 32'($onehot0(out1)), 32'd1);
            if (out1 != 2'b00) chk("w1 out matches idx", 32'(out1), 32'(2'b01 << idx1));
            if (done1) chk("w1 done implies busy", 32'(busy1), 32'd1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] e8;
        rst3 = 1'b0; en3 = 1'b0; sw3 = 1'b0; in3 = '0;
        rst1 = 1'b0; en1 = 1'b0; sw1 = 1'b0; in1 = '0;
        @(posedge clk); #1;

        // Reset held: outputs stay zero even with enable driven.
        step3(0, 1, 3'd5, 8'h00, 3'd0, 0, 0);
        step3(0, 1, 3'd5, 8'h00, 3'd0, 0, 0);
        rst3 = 1'b1; rst1 = 1'b1;

        // Normal decode, back-to-back, then disable.
        step3(0, 1, 3'd5, 8'h20, 3'd5, 0, 0);
        step3(0, 1, 3'd0, 8'h01, 3'd0, 0, 0);
        step3(0, 1, 3'd7, 8'h80, 3'd7, 0, 0);
        step3(0, 0, 3'd3, 8'h00, 3'd0, 0, 0);

        // Full sweep.
        step3(1, 0, 3'd0, 8'h01, 3'd0, 1, 0);
        for (int i = 1; i < 8; i++) begin
            e8 = 8'h01 << i;
            step3(0, 0, 3'd0, e8, 3'(i), 1, 0);
        end
        step3(0, 0, 3'd0, 8'h00, 3'd0, 1, 1);
        step3(0, 0, 3'd0, 8'h00, 3'd0, 0, 0);

        // Sweep start beats enable; toggled inputs during sweep are ignored.
        step3(1, 1, 3'd6, 8'h01, 3'd0, 1, 0);
        for (int i = 1; i < 8; i++) begin
            e8 = 8'h01 << i;
            step3(1'(i % 2), 1'(i % 2 == 0), 3'(7 - i), e8, 3'(i), 1, 0);
        end
        step3(1, 1, 3'd6, 8'h00, 3'd0, 1, 1);
        // Start held through DONE is not honoured there.
        step3(1, 1, 3'd6, 8'h00, 3'd0, 0, 0);
        step3(0, 1, 3'd1, 8'h02, 3'd1, 0, 0);

        // Reset mid-sweep at index 4.
        step3(1, 0, 3'd0, 8'h01, 3'd0, 1, 0);
        for (int i = 1; i < 5; i++) begin
            e8 = 8'h01 << i;
            step3(0, 0, 3'd0, e8, 3'(i), 1, 0);
        end
        @(negedge clk); #1;
        rst3 = 1'b0;
        #1;
        chk("w3 async reset out_o", 32'(out3), 32'd0);
        chk("w3 async reset out_idx_o", 32'(idx3), 32'd0);
        chk("w3 async reset busy_o", 32'(busy3), 32'd0);
        chk("w3 async reset done_o", 32'(done3), 32'd0);
        step3(0, 0, 3'd0, 8'h00, 3'd0, 0, 0);
        rst3 = 1'b1;
        step3(0, 1, 3'd2, 8'h04, 3'd2, 0, 0);
        step3(0, 0, 3'd0, 8'h00, 3'd0, 0, 0);
        step3(0, 0, 3'd0, 8'h00, 3'd0, 0, 0);

        // Minimum width.
        step1(0, 1, 1'b1, 2'b10, 1'b1, 0, 0);
        step1(1, 1, 1'b1, 2'b01, 1'b0, 1, 0);
        step1(1, 0, 1'b0, 2'b10, 1'b1, 1, 0);
        step1(1, 1, 1'b0, 2'b00, 1'b0, 1, 1);
        step1(0, 0, 1'b0, 2'b00, 1'b0, 0, 0);
        step1(0, 1, 1'b0, 2'b01, 1'b0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("w3 scoreboard drained", 32'(q3.size()), 32'd0);
        chk("w1 scoreboard drained", 32'(q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/decoder_e_sweep.md
# decoder_e_sweep

Registered, parametrised enabled N-to-2^N decoder. It drives one-hot write-enable lines, for example register-file write selects in the CPU datapath. It adds a self-timed sweep mode that asserts every output line once, in ascending order, so that register-file clear or initialisation needs no external address sequencing. All outputs come directly from flops.

## Interface
- INPUT_LENGTH, 5, select width in bits; legal range 1..8.
- OUTPUT_WIDTH, 2 ** INPUT_LENGTH, number of one-hot output lines. Derived only; never overridden.

- clk_i  input  1  single clock; all state updates on its rising edge.
- rst_n_i  input  1  reset; asynchronous, active-low. Assertion immediately forces the reset values below. Deassertion is synchronised externally.
- in_i  input  INPUT_LENGTH  select index for normal decode.
- enable_i  input  1  normal-decode enable.
- sweep_start_i  input  1  single-cycle request to begin a sweep; honoured only in IDLE.
- out_o  output  OUTPUT_WIDTH  registered one-hot enables; all-zero when inactive.
- out_idx_o  output  INPUT_LENGTH  binary index of the asserted out_o bit; 0 when out_o is zero.
- busy_o  output  1  high while a sweep is in progress (states SWEEP and DONE).
- done_o  output  1  one-cycle pulse marking sweep completion.

## Operation
- Reset values:
  - out_o = 0, out_idx_o = 0, busy_o = 0, done_o = 0.
  - State = IDLE; sweep counter = 0.
- State machine with three states: IDLE, SWEEP, DONE.
- IDLE, sweep_start_i = 0:
  - out_o <= enable_i ? (1 << in_i) : 0.
  - out_idx_o <= enable_i ? in_i : 0.
  - done_o <= 0.
- IDLE, sweep_start_i = 1:
  - Go to SWEEP.
  - out_o <= 1 (bit 0), out_idx_o <= 0, counter <= 1, busy_o <= 1.
  - enable_i and in_i are ignored for this cycle; sweep takes priority.
- SWEEP:
  - out_o <= 1 << counter, out_idx_o <= counter, counter <= counter + 1.
  - Once bit OUTPUT_WIDTH-1 has been issued, the next edge goes to DONE.
  - in_i, enable_i and sweep_start_i are ignored throughout.
- DONE:
  - out_o <= 0, out_idx_o <= 0, done_o <= 1, busy_o stays 1, counter <= 0.
  - Next edge returns to IDLE, with done_o <= 0 and busy_o <= 0.
- Counter width is INPUT_LENGTH + 1 so that reaching OUTPUT_WIDTH does not wrap. The compare is against OUTPUT_WIDTH, not against zero.
- Invariants:
  - out_o has at most one bit set in every cycle.
  - When out_o is non-zero, out_o == 1 << out_idx_o.
  - done_o implies busy_o.
- sweep_start_i held high across a sweep does not restart it. A new sweep begins only if sweep_start_i is high in an IDLE cycle, which is at the earliest the cycle after DONE.
- Reset asserted mid-sweep: the sweep aborts immediately to the reset values. No done_o pulse is produced.

## Timing
- Normal decode latency is 1 cycle. Inputs sampled at edge k appear on out_o after edge k; back-to-back selects give back-to-back outputs.
- Sweep timeline, with start sampled at edge s:
  - out_o bit i is high after edge s+i, for i = 0..OUTPUT_WIDTH-1.
  - done_o is high after edge s+OUTPUT_WIDTH.
  - IDLE is resumed after edge s+OUTPUT_WIDTH+1.
- busy_o is high for exactly OUTPUT_WIDTH+1 cycles per sweep.
- With INPUT_LENGTH = 1, the sweep is 2 output cycles plus 1 DONE cycle.
- No combinational path from any input to any output.

## Test plan
- Reset and normal decode, INPUT_LENGTH=3:
  - Stimulus: hold rst_n_i=0, then release; drive enable_i=1 with in_i=5, then 0, then 7.
  - Response: all outputs 0 during reset; then out_o = 8'b0010_0000, 8'b0000_0001, 8'b1000_0000 on consecutive cycles, with out_idx_o = 5, 0, 7.
- Disable:
  - Stimulus: enable_i=0, in_i=3.
  - Response: out_o=0 and out_idx_o=0 the next cycle.
- Full sweep, INPUT_LENGTH=3:
  - Stimulus: pulse sweep_start_i for one cycle.
  - Response: out_idx_o = 0,1,…,7 with matching one-hot out_o over 8 cycles; then out_o=0 with done_o=1 for 1 cycle; busy_o high for 9 cycles; then back to IDLE.
- Priority and ignore:
  - Stimulus: assert sweep_start_i together with enable_i=1, in_i=6; then toggle enable_i, in_i and sweep_start_i during the sweep.
  - Response: the first output is bit 0, not bit 6; the sweep sequence is unchanged and not restarted.
- Reset mid-sweep:
  - Stimulus: assert rst_n_i=0 asynchronously when out_idx_o=4.
  - Response: all outputs go to 0 immediately, with no done_o. After release, enable_i=1 with in_i=2 gives out_o = 8'b0000_0100.
- Minimum width, INPUT_LENGTH=1:
  - Stimulus: start a sweep.
  - Response: out_o = 2'b01, then 2'b10, then done_o pulse; busy_o high for 3 cycles. The one-hot assertion holds throughout.
